// File: rtl/pc_unit_ras_pkg.sv
// pc_pkg: shared types and helpers for the program-counter unit.
//   npc_sel_e   - which source feeds the next PC.
//   npc_select  - resolves simultaneous control requests into one selection,
//                 highest priority first: stall, ret, call, taken branch, jmp,
//                 sequential.
package pc_pkg;

    typedef enum logic [2:0] {
        NPC_HOLD,
        NPC_SEQ,
        NPC_BR,
        NPC_JMP,
        NPC_CALL,
        NPC_RET
    } npc_sel_e;

    function automatic npc_sel_e npc_select(
        input logic stall,
        input logic ret,
        input logic call,
        input logic br_taken,
        input logic jmp
    );
        if (stall)         return NPC_HOLD;
        else if (ret)      return NPC_RET;
        else if (call)     return NPC_CALL;
        else if (br_taken) return NPC_BR;
        else if (jmp)      return NPC_JMP;
        else               return NPC_SEQ;
    endfunction

endpackage

// File: rtl/pc_unit_ras_stack.sv
// ras_stack: circular return-address stack.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   push, pop       - push has priority if both are high (the caller never
//                     asserts both)
//   push_data       - address written on push
//   top             - most recently pushed entry (valid while count > 0)
//   count           - number of valid entries, saturates at RAS_DEPTH
//   overflow        - sticky: push while full (oldest entry overwritten)
//   underflow       - sticky: pop while empty (nothing changes)
// RAS_DEPTH must be a power of two >= 2 so the pointer wraps for free.
module ras_stack #(
    parameter int unsigned RAS_DEPTH = 8,
    parameter int unsigned ADDR_W    = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [ADDR_W-1:0]            push_data,
    output logic [ADDR_W-1:0]            top,
    output logic [$clog2(RAS_DEPTH):0]   count,
    output logic                         overflow,
    output logic                         underflow
);
    import pc_pkg::*;

    localparam int unsigned PW = $clog2(RAS_DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [ADDR_W-1:0] mem_d [RAS_DEPTH];
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic [PW-1:0]     ptr_m1;

    // The pointer addresses the next free slot; the top sits just below it.
    assign ptr_m1 = ptr_q - PW'(1);

    always_comb begin
        mem_d = mem_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        if (push) begin
            mem_d[ptr_q] = push_data;
            ptr_d        = ptr_q + PW'(1);
            if (cnt_q == CW'(RAS_DEPTH)) ovf_d = 1'b1;  // wrapped onto oldest
            else                          cnt_d = cnt_q + CW'(1);
        end else if (pop) begin
            if (cnt_q != '0) begin
                ptr_d = ptr_m1;
                cnt_d = cnt_q - CW'(1);
            end else begin
                unf_d = 1'b1;
            end
        end
    end

    // Entry contents need no reset; only the bookkeeping does.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign top       = mem_q[ptr_m1];
    assign count     = cnt_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: rtl/pc_unit_ras.sv
// pc_unit_ras: fetch program counter with branch, jump and call/return via a
// circular return-address stack.
// Ports:
//   clk, rst, clr          - clock; rst and clr both reset synchronously
//   stall                  - hold PC and stack; requests this cycle are dropped
//   branch, zero, br_off   - PC-relative branch taken when branch & zero
//   jmp, call, tgt_addr    - absolute jump / jump-and-link to tgt_addr
//   ret                    - pop the stack into the PC
//   pc                     - registered fetch address
//   ras_count              - valid stack entries
//   ras_overflow/underflow - sticky stack error flags
module pc_unit_ras #(
    parameter int unsigned       ADDR_W     = 32,
    parameter int unsigned       INC        = 1,
    parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
    parameter int unsigned       RAS_DEPTH  = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        stall,
    input  logic                        branch,
    input  logic                        zero,
    input  logic [ADDR_W-1:0]           br_off,
    input  logic                        jmp,
    input  logic                        call,
    input  logic                        ret,
    input  logic [ADDR_W-1:0]           tgt_addr,
    output logic [ADDR_W-1:0]           pc,
    output logic [$clog2(RAS_DEPTH):0]  ras_count,
    output logic                        ras_overflow,
    output logic                        ras_underflow
);
    import pc_pkg::*;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] ras_top;
    logic              ras_rst;
    npc_sel_e          sel;

    assign sel     = npc_select(stall, ret, call, branch & zero, jmp);
    assign pc_inc  = pc_q + ADDR_W'(INC);
    assign ras_rst = rst | clr;

    always_comb begin
        pc_d = pc_q;
        case (sel)
            NPC_HOLD: pc_d = pc_q;
            // An empty-stack return falls through to sequential fetch.
            NPC_RET:  pc_d = (ras_count != '0) ? ras_top : pc_inc;
            NPC_CALL: pc_d = tgt_addr;
            NPC_BR:   pc_d = pc_q + br_off;  // two's-complement wrap
            NPC_JMP:  pc_d = tgt_addr;
            default:  pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst || clr) pc_q <= RESET_ADDR;
        else            pc_q <= pc_d;
    end

    ras_stack #(
        .RAS_DEPTH (RAS_DEPTH),
        .ADDR_W    (ADDR_W)
    ) u_ras (
        .clk       (clk),
        .rst       (ras_rst),
        .push      (sel == NPC_CALL),
        .pop       (sel == NPC_RET),
        .push_data (pc_inc),
        .top       (ras_top),
        .count     (ras_count),
        .overflow  (ras_overflow),
        .underflow (ras_underflow)
    );

    assign pc = pc_q;

endmodule

// File: tb/tb_pc_unit_ras.sv
module tb_pc_unit_ras;
    logic        clk = 1'b0;
    logic        rst, clr, stall, branch, zero, jmp, call, ret;
    logic [31:0] br_off, tgt_addr;
    logic [31:0] pc;
    logic [2:0]  ras_count;
    logic        ras_overflow, ras_underflow;

    int total = 0;
    int bad   = 0;

    pc_unit_ras #(
        .ADDR_W     (32),
        .INC        (1),
        .RESET_ADDR (32'h100),
        .RAS_DEPTH  (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .clr           (clr),
        .stall         (stall),
        .branch        (branch),
        .zero          (zero),
        .br_off        (br_off),
        .jmp           (jmp),
        .call          (call),
        .ret           (ret),
        .tgt_addr      (tgt_addr),
        .pc            (pc),
        .ras_count     (ras_count),
        .ras_overflow  (ras_overflow),
        .ras_underflow (ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic idle_in();
        rst = 0; clr = 0; stall = 0; branch = 0; zero = 0; jmp = 0;
        call = 0; ret = 0; br_off = '0; tgt_addr = '0;
    endtask

    // One clock with whatever inputs are currently driven, then release them.
    task automatic tick();
        @(posedge clk);
        #1;
        idle_in();
    endtask

    task automatic do_jmp(input logic [31:0] t);
        jmp = 1; tgt_addr = t; tick();
    endtask

    task automatic do_call(input logic [31:0] t);
        call = 1; tgt_addr = t; tick();
    endtask

    task automatic do_ret();
        ret = 1; tick();
    endtask

    initial begin
        idle_in();
        // reset sequencing
        rst = 1; call = 1; tgt_addr = 32'h55; tick();
        rst = 1; tick();
        chk("rst_pc", pc, 32'h100);
        chk("rst_cnt", 32'(ras_count), 0);
        chk("rst_ovf", 32'(ras_overflow), 0);
        chk("rst_unf", 32'(ras_underflow), 0);
        tick(); chk("seq1", pc, 32'h101);
        tick(); chk("seq2", pc, 32'h102);
        tick(); chk("seq3", pc, 32'h103);
        clr = 1; tick(); chk("clr_pc", pc, 32'h100);

        // branches
        do_jmp(32'h10); chk("jmp", pc, 32'h10);
        branch = 1; zero = 1; br_off = 32'd5; tick();
        chk("br_pos", pc, 32'h15);
        branch = 1; zero = 1; br_off = 32'hFFFF_FFFE; tick();
        chk("br_neg", pc, 32'h13);
        branch = 1; zero = 0; br_off = 32'd40; tick();
        chk("br_nt", pc, 32'h14);
        // taken branch beats jmp
        branch = 1; zero = 1; br_off = 32'd2; jmp = 1; tgt_addr = 32'h999; tick();
        chk("br_over_jmp", pc, 32'h16);
        // untaken branch falls through to jmp
        branch = 1; zero = 0; br_off = 32'd2; jmp = 1; tgt_addr = 32'h30; tick();
        chk("nt_jmp", pc, 32'h30);

        // nested call / return
        do_jmp(32'h08);
        do_call(32'h40); chk("call1_pc", pc, 32'h40);
        do_call(32'h80);
        chk("call2_pc", pc, 32'h80);
        chk("call2_cnt", 32'(ras_count), 2);
        do_ret(); chk("ret1_pc", pc, 32'h41);
        do_ret(); chk("ret2_pc", pc, 32'h09);
        chk("ret2_cnt", 32'(ras_count), 0);
        chk("ret2_ovf", 32'(ras_overflow), 0);
        chk("ret2_unf", 32'(ras_underflow), 0);

        // overflow / underflow, depth 4: calls from 0x200,0x300,...,0x600
        do_jmp(32'h200);
        do_call(32'h300);
        do_call(32'h400);
        do_call(32'h500);
        do_call(32'h600);
        chk("pre_ovf", 32'(ras_overflow), 0);
        do_call(32'h700);
        chk("ovf_flag", 32'(ras_overflow), 1);
        chk("ovf_cnt", 32'(ras_count), 4);
        do_ret(); chk("oret1", pc, 32'h601);
        do_ret(); chk("oret2", pc, 32'h501);
        do_ret(); chk("oret3", pc, 32'h401);
        do_ret(); chk("oret4", pc, 32'h301);
        chk("oret_unf0", 32'(ras_underflow), 0);
        do_ret(); chk("unf_pc", pc, 32'h302);
        chk("unf_flag", 32'(ras_underflow), 1);
        chk("unf_cnt", 32'(ras_count), 0);
        tick(); chk("sticky_ovf", 32'(ras_overflow), 1);
        chk("sticky_unf", 32'(ras_underflow), 1);

        // priority and stall
        clr = 1; tick();
        chk("clr_ovf", 32'(ras_overflow), 0);
        chk("clr_unf", 32'(ras_underflow), 0);
        do_call(32'h50);
        chk("pcall_cnt", 32'(ras_count), 1);
        stall = 1; call = 1; jmp = 1; tgt_addr = 32'h77; tick();
        stall = 1; call = 1; jmp = 1; tgt_addr = 32'h77; tick();
        chk("stall_pc", pc, 32'h50);
        chk("stall_cnt", 32'(ras_count), 1);
        ret = 1; call = 1; jmp = 1; tgt_addr = 32'h77; tick();
        chk("prio_pc", pc, 32'h101);
        chk("prio_cnt", 32'(ras_count), 0);
        chk("prio_ovf", 32'(ras_overflow), 0);

        // reset overrides a call
        do_call(32'h60);
        rst = 1; call = 1; tgt_addr = 32'h70; tick();
        chk("rst_call_pc", pc, 32'h100);
        chk("rst_call_cnt", 32'(ras_count), 0);

        // wrap
        do_jmp(32'hFFFF_FFFF);
        tick(); chk("wrap", pc, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/pc_unit_ras.md
Name: pc_unit_ras

Overview:
Parametrised program-counter unit for the MIPS core. It generalises the basic PC with:
- configurable address width and increment
- a reset vector
- a stall/hold input
- signed PC-relative branches
- absolute jumps
- call/return through a circular return-address stack (RAS) with overflow/underflow reporting

It sits between the control unit and instruction memory and drives the fetch address every cycle.

Parameters:
- ADDR_W, 32, width of the PC and all address/offset inputs.
- INC, 1, sequential increment (1 = word-addressed instruction memory, 4 = byte-addressed).
- RESET_ADDR, 0, PC value loaded on rst or clr.
- RAS_DEPTH, 8, number of return-stack entries; must be a power of two and at least 2.

Ports:
- clk, input, 1, clock.
- rst, input, 1, reset, synchronous, active-high.
- clr, input, 1, synchronous soft clear; same effect as rst.
- stall, input, 1, hold the PC and RAS unchanged this cycle.
- branch, input, 1, conditional branch instruction.
- zero, input, 1, ALU zero flag; the branch is taken when branch & zero.
- br_off, input, ADDR_W, two's-complement PC-relative offset.
- jmp, input, 1, absolute jump.
- call, input, 1, jump-and-link: push the return address, then jump.
- ret, input, 1, return: pop the RAS into the PC.
- tgt_addr, input, ADDR_W, absolute target for jmp and call.
- pc, output, ADDR_W, current fetch address.
- ras_count, output, $clog2(RAS_DEPTH)+1, number of valid RAS entries.
- ras_overflow, output, 1, sticky: a push occurred while the RAS was full.
- ras_underflow, output, 1, sticky: a pop occurred while the RAS was empty.

Behaviour:
- All state updates on the posedge of clk. No combinational path from inputs to pc; next PC takes effect one cycle after the request.
- Reset (rst or clr):
  - pc = RESET_ADDR, ras_count = 0, ras_overflow = 0, ras_underflow = 0.
  - Stack pointer = 0. Entry contents are don't-care.
  - Reset overrides every other input, including mid-call or mid-return.
- Priority when not in reset, highest first: stall > ret > call > (branch & zero) > jmp > sequential.
  - Lower-priority requests asserted in the same cycle are ignored; no side effects.
- stall: pc, RAS, count and flags all hold. Requests present during stall are dropped, not queued.
- ret:
  - ras_count > 0: pc <= top entry; pointer decrements; ras_count decrements.
  - ras_count == 0: pc <= pc + INC; pointer and count unchanged; ras_underflow <= 1.
- call:
  - pc <= tgt_addr; push (pc + INC) at the pointer; pointer increments modulo RAS_DEPTH.
  - ras_count < RAS_DEPTH: ras_count increments.
  - ras_count == RAS_DEPTH: the oldest entry is overwritten (circular); count stays at RAS_DEPTH; ras_overflow <= 1.
- branch taken (branch & zero): pc <= pc + br_off.
  - Full ADDR_W two's-complement add; wraps modulo 2^ADDR_W.
  - Negative offsets need no special-case logic.
- branch with zero == 0: treated as no request; falls through to jmp or sequential.
- jmp: pc <= tgt_addr.
- Sequential: pc <= pc + INC, wrapping modulo 2^ADDR_W (all-ones + 1 -> 0 when INC = 1).
- Sticky flags clear only on rst or clr.
- After an overflow, returns yield the most recent RAS_DEPTH addresses in LIFO order. A further return once those are exhausted underflows.

Decomposition:
- Package pc_pkg:
  - enum npc_sel_e {NPC_HOLD, NPC_SEQ, NPC_BR, NPC_JMP, NPC_CALL, NPC_RET}.
  - Function computing the selection from the request bits per the priority list above.
- Sub-module ras_stack:
  - Parameters RAS_DEPTH and ADDR_W.
  - Ports: clk, rst, push, pop, push_data, top, count, overflow, underflow.
  - Circular buffer with pointer and saturating count.
- pc_unit_ras contains the next-PC mux, the PC register and one ras_stack instance.

Test Plan:
- Reset/clr sequencing (RESET_ADDR = 0x100, INC = 1): assert rst, release, run 3 idle cycles -> pc = 0x100, 0x101, 0x102, 0x103. Then assert clr for 1 cycle -> pc = 0x100.
- Branch, positive offset: at pc = 0x10, branch = 1, zero = 1, br_off = 5 -> pc = 0x15.
- Branch, negative offset: from pc = 0x15, br_off = 0xFFFFFFFE -> pc = 0x13.
- Branch not taken: branch = 1, zero = 0 -> pc = 0x14.
- Nested call/return: call tgt = 0x40 at pc = 0x08; then call tgt = 0x80 at pc = 0x40.
  - Expect pc = 0x80, ras_count = 2.
  - ret -> pc = 0x41; ret -> pc = 0x09; ras_count = 0, no flags.
- Overflow/underflow (RAS_DEPTH = 4): 5 consecutive calls from pcs A0..A4.
  - Expect ras_overflow = 1, ras_count = 4.
  - 4 rets -> pc = A4+1, A3+1, A2+1, A1+1.
  - 5th ret -> pc = A1+2, ras_underflow = 1.
- Priority and stall:
  - stall = 1 with call = 1, jmp = 1 for 2 cycles -> pc and ras_count unchanged.
  - Then ret = 1, call = 1, jmp = 1 together with a non-empty stack -> pop only; tgt_addr ignored; no push.
- Wrap: pc = 0xFFFFFFFF, idle cycle -> pc = 0x00000000.
